// File: rtl/arbiter_n_to_1_request_wrr.sv
// N-to-1 request arbiter (RR / WRR / fixed priority) fed by per-channel fall-through FIFOs into one output register.
// Push at edge t can leave at edge t+1; the output register and FIFOs hold while out_valid & ~out_ready.

module sync_fifo #(
    parameter  int DW    = 64,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          ap_clk,
    input  logic          areset_n,
    input  logic          wr_vld,
    input  logic [DW-1:0] wr_dat,
    output logic          wr_acc,
    input  logic          rd_en,
    output logic [DW-1:0] rd_dat,
    output logic          empty,
    output logic [CW-1:0] cnt
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          rd_acc;

    assign full   = (cnt == CW'(DEPTH));
    assign empty  = (cnt == '0);
    assign rd_acc = rd_en & ~empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_acc = wr_vld & (~full | rd_acc);
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge ap_clk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (wr_acc) mem[wr_ptr] <= wr_dat;
    end
endmodule

module arbiter_n_to_1_request_wrr #(
    parameter int NUM_REQUESTOR = 4,
    parameter int DATA_WIDTH    = 64,
    parameter int FIFO_DEPTH    = 16,
    parameter int PROG_THRESH   = 12,
    parameter int WEIGHT_WIDTH  = 4,
    parameter int ID_WIDTH      = (NUM_REQUESTOR > 1) ? $clog2(NUM_REQUESTOR) : 1
) (
    input  logic                                  ap_clk,
    input  logic                                  areset_n,
    input  logic [1:0]                            mode_in,
    input  logic [NUM_REQUESTOR*WEIGHT_WIDTH-1:0] weight_in,
    input  logic [NUM_REQUESTOR-1:0]              request_valid_in,
    input  logic [NUM_REQUESTOR*DATA_WIDTH-1:0]   request_data_in,
    output logic [NUM_REQUESTOR-1:0]              request_ready_out,
    output logic                                  request_out_valid,
    output logic [DATA_WIDTH-1:0]                 request_out_data,
    output logic [ID_WIDTH-1:0]                   request_out_id,
    input  logic                                  request_out_ready,
    output logic [NUM_REQUESTOR-1:0]              overflow_out
);
    localparam int NUM = NUM_REQUESTOR;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int XW  = ID_WIDTH + 1;

    localparam logic [1:0] MODE_WRR = 2'd1;
    localparam logic [1:0] MODE_FIX = 2'd2;

    logic [NUM-1:0]          fifo_empty;
    logic [NUM-1:0]          fifo_wr_acc;
    logic [NUM-1:0]          pop;
    logic [NUM-1:0]          cand;
    logic [CW-1:0]           fifo_cnt [NUM];
    logic [CW-1:0]           cnt_nxt  [NUM];
    logic [DATA_WIDTH-1:0]   fifo_dat [NUM];
    logic [WEIGHT_WIDTH-1:0] weight   [NUM];

    logic [ID_WIDTH-1:0]     rr_ptr;
    logic [ID_WIDTH-1:0]     holder;
    logic [ID_WIDTH-1:0]     winner;
    logic [XW-1:0]           idx;
    logic [WEIGHT_WIDTH-1:0] credit;
    logic [WEIGHT_WIDTH-1:0] credit_eff;
    logic [WEIGHT_WIDTH-1:0] credit_nxt;
    logic [WEIGHT_WIDTH-1:0] wsel;
    logic [1:0]              mode_q;
    logic                    adv;
    logic                    grant;
    logic                    is_rr;

    for (genvar g = 0; g < NUM; g++) begin : g_ch
        sync_fifo #(
            .DW    (DATA_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .ap_clk   (ap_clk),
            .areset_n (areset_n),
            .wr_vld   (request_valid_in[g]),
            .wr_dat   (request_data_in[g*DATA_WIDTH +: DATA_WIDTH]),
            .wr_acc   (fifo_wr_acc[g]),
            .rd_en    (pop[g]),
            .rd_dat   (fifo_dat[g]),
            .empty    (fifo_empty[g]),
            .cnt      (fifo_cnt[g])
        );
        assign weight[g]  = weight_in[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        assign cnt_nxt[g] = fifo_cnt[g] + CW'(fifo_wr_acc[g]) - CW'(pop[g]);
    end

    assign cand  = ~fifo_empty;
    assign adv   = ~request_out_valid | request_out_ready;
    assign grant = adv & (|cand);
    assign is_rr = (mode_in != MODE_WRR) && (mode_in != MODE_FIX);
    // A mode switch forfeits any WRR credit, including on the switching grant itself.
    assign credit_eff = (mode_in != mode_q) ? '0 : credit;

    // Searches run downwards so the nearest eligible channel is the last assignment.
    always_comb begin
        winner     = '0;
        credit_nxt = credit_eff;
        wsel       = '0;
        idx        = '0;
        case (mode_in)
            MODE_WRR: begin
                if ((credit_eff != '0) && cand[holder]) begin
                    winner     = holder;
                    credit_nxt = credit_eff - 1'b1;
                end else begin
                    for (int k = NUM; k >= 1; k--) begin
                        idx = {1'b0, holder} + XW'(k);
                        if (idx >= XW'(NUM)) idx = idx - XW'(NUM);
                        if (cand[idx[ID_WIDTH-1:0]]) winner = idx[ID_WIDTH-1:0];
                    end
                    wsel       = weight[winner];
                    credit_nxt = (wsel == '0) ? '0 : wsel - 1'b1;
                end
            end
            MODE_FIX: begin
                for (int k = NUM - 1; k >= 0; k--) begin
                    if (cand[k]) winner = ID_WIDTH'(k);
                end
            end
            default: begin
                for (int k = NUM - 1; k >= 0; k--) begin
                    idx = {1'b0, rr_ptr} + XW'(k);
                    if (idx >= XW'(NUM)) idx = idx - XW'(NUM);
                    if (cand[idx[ID_WIDTH-1:0]]) winner = idx[ID_WIDTH-1:0];
                end
            end
        endcase
    end

    always_comb begin
        pop = '0;
        if (grant) pop[winner] = 1'b1;
    end

    always_ff @(posedge ap_clk or negedge areset_n) begin
        if (!areset_n) begin
            request_out_valid <= 1'b0;
            request_out_data  <= '0;
            request_out_id    <= '0;
            rr_ptr            <= '0;
            holder            <= '0;
            credit            <= '0;
            mode_q            <= '0;
        end else begin
            mode_q <= mode_in;
            if (grant) begin
                request_out_valid <= 1'b1;
                request_out_data  <= fifo_dat[winner];
                request_out_id    <= winner;
            end else if (adv) begin
                request_out_valid <= 1'b0;
            end
            if (grant && is_rr) begin
                rr_ptr <= (winner == ID_WIDTH'(NUM - 1)) ? '0 : winner + 1'b1;
            end
            if (grant && (mode_in == MODE_WRR)) begin
                holder <= winner;
                credit <= credit_nxt;
            end else begin
                credit <= credit_eff;
            end
        end
    end

    // Ready tracks the occupancy the FIFO will hold after this edge.
    always_ff @(posedge ap_clk or negedge areset_n) begin
        if (!areset_n) begin
            request_ready_out <= '0;
            overflow_out      <= '0;
        end else begin
            for (int i = 0; i < NUM; i++) begin
                request_ready_out[i] <= (cnt_nxt[i] < CW'(PROG_THRESH));
            end
            overflow_out <= overflow_out | (request_valid_in & ~fifo_wr_acc);
        end
    end
endmodule

// File: tb/tb_arbiter_n_to_1_request_wrr.sv
// Random and directed stimulus against a queue-based behavioural model of the arbiter.
module tb_arbiter_n_to_1_request_wrr;
    localparam int N      = 4;
    localparam int DW     = 64;
    localparam int DEPTH  = 16;
    localparam int THRESH = 12;
    localparam int WW     = 4;
    localparam int IW     = 2;

    logic            ap_clk = 1'b0;
    logic            areset_n;
    logic [1:0]      mode_in;
    logic [N*WW-1:0] weight_in;
    logic [N-1:0]    request_valid_in;
    logic [N*DW-1:0] request_data_in;
    logic [N-1:0]    request_ready_out;
    logic            request_out_valid;
    logic [DW-1:0]   request_out_data;
    logic [IW-1:0]   request_out_id;
    logic            request_out_ready;
    logic [N-1:0]    overflow_out;

    always #5 ap_clk = ~ap_clk;

    arbiter_n_to_1_request_wrr #(
        .NUM_REQUESTOR (N),
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .PROG_THRESH   (THRESH),
        .WEIGHT_WIDTH  (WW),
        .ID_WIDTH      (IW)
    ) dut (
        .ap_clk            (ap_clk),
        .areset_n          (areset_n),
        .mode_in           (mode_in),
        .weight_in         (weight_in),
        .request_valid_in  (request_valid_in),
        .request_data_in   (request_data_in),
        .request_ready_out (request_ready_out),
        .request_out_valid (request_out_valid),
        .request_out_data  (request_out_data),
        .request_out_id    (request_out_id),
        .request_out_ready (request_out_ready),
        .overflow_out      (overflow_out)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] mq [N][$];
    bit            m_vld;
    logic [DW-1:0] m_data;
    int            m_id;
    bit [N-1:0]    m_rdy;
    bit [N-1:0]    m_ovf;
    int            m_ptr;
    int            m_holder;
    int            m_credit;
    int            m_mode;

    int            obs_id  [$];
    logic [DW-1:0] obs_dat [$];
    int            obs_cyc [$];
    logic [DW-1:0] pushed  [$];
    int            pat [7] = '{0, 1, 1, 2, 2, 2, 3};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_vld = 0; m_data = '0; m_id = 0; m_rdy = '0; m_ovf = '0;
        m_ptr = 0; m_holder = 0; m_credit = 0; m_mode = 0;
    endfunction

    function automatic int pick();
        int w = 0;
        int wt;
        case (int'(mode_in))
            1: begin
                if (m_credit > 0 && mq[m_holder].size() > 0) begin
                    w = m_holder;
                    m_credit--;
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        if (mq[(m_holder + k) % N].size() > 0) begin
                            w = (m_holder + k) % N;
                            break;
                        end
                    end
                    wt = int'(weight_in[w*WW +: WW]);
                    if (wt == 0) wt = 1;
                    m_holder = w;
                    m_credit = wt - 1;
                end
            end
            2: begin
                for (int k = N - 1; k >= 0; k--) if (mq[k].size() > 0) w = k;
            end
            default: begin
                for (int k = 0; k < N; k++) begin
                    if (mq[(m_ptr + k) % N].size() > 0) begin
                        w = (m_ptr + k) % N;
                        break;
                    end
                end
                m_ptr = (w + 1) % N;
            end
        endcase
        return w;
    endfunction

    function automatic void model_edge();
        bit adv = !m_vld || request_out_ready;
        bit any = 0;
        int w;
        if (int'(mode_in) != m_mode) begin
            m_credit = 0;
            m_mode   = int'(mode_in);
        end
        for (int i = 0; i < N; i++) if (mq[i].size() > 0) any = 1;
        if (adv && any) begin
            w      = pick();
            m_data = mq[w].pop_front();
            m_id   = w;
            m_vld  = 1;
        end else if (adv) begin
            m_vld = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (request_valid_in[i]) begin
                if (mq[i].size() < DEPTH) mq[i].push_back(request_data_in[i*DW +: DW]);
                else m_ovf[i] = 1;
            end
            m_rdy[i] = (mq[i].size() < THRESH);
        end
    endfunction

    task automatic drive(input bit [N-1:0] v);
        logic [DW-1:0] d;
        request_valid_in = v;
        for (int i = 0; i < N; i++) begin
            d = {$urandom, $urandom};
            request_data_in[i*DW +: DW] = d;
            if (v[i]) pushed.push_back(d);
        end
    endtask

    task automatic step();
        model_edge();
        if (request_out_valid && request_out_ready) begin
            obs_id.push_back(int'(request_out_id));
            obs_dat.push_back(request_out_data);
            obs_cyc.push_back(cyc);
        end
        @(posedge ap_clk);
        #1;
        cyc++;
        check_eq("out_valid", request_out_valid, m_vld);
        if (m_vld) begin
            check_eq("out_data", request_out_data, m_data);
            check_eq("out_id", request_out_id, m_id);
        end
        check_eq("ready", request_ready_out, m_rdy);
        check_eq("overflow", overflow_out, m_ovf);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_valid", request_out_valid, 0);
        check_eq("rst_data", request_out_data, 0);
        check_eq("rst_id", request_out_id, 0);
        check_eq("rst_ready", request_ready_out, 0);
        check_eq("rst_overflow", overflow_out, 0);
    endtask

    task automatic do_reset();
        #2;
        areset_n = 1'b0;
        #1;
        check_reset_outputs();
        request_valid_in = '0;
        @(posedge ap_clk);
        #3;
        areset_n = 1'b1;
        model_reset();
        obs_id.delete(); obs_dat.delete(); obs_cyc.delete(); pushed.delete();
    endtask

    initial begin
        bit [N-1:0] v;
        int f;
        areset_n          = 1'b0;
        mode_in           = 2'd0;
        weight_in         = '0;
        request_valid_in  = '0;
        request_data_in   = '0;
        request_out_ready = 1'b0;
        model_reset();
        #1;
        check_reset_outputs();
        #12;
        areset_n = 1'b1;

        // Round robin, all four channels loaded together.
        request_out_ready = 1'b1;
        repeat (4) begin drive('1); step(); end
        drive('0);
        repeat (18) step();
        check_eq("t2_count", obs_id.size(), 16);
        for (int k = 0; k < 16 && k < obs_id.size(); k++) check_eq("t2_id", obs_id[k], k % 4);

        // Weighted round robin, weights {1,2,3,0}, backlog kept on every channel.
        do_reset();
        mode_in   = 2'd1;
        weight_in = {4'd0, 4'd3, 4'd2, 4'd1};
        repeat (60) begin
            v = '0;
            for (int i = 0; i < N; i++) if (mq[i].size() < 4) v[i] = 1'b1;
            drive(v);
            step();
        end
        f = -1;
        for (int k = 0; k < obs_id.size(); k++) if (f < 0 && obs_id[k] == 0) f = k;
        check_eq("t3_window", (f >= 0) && (obs_id.size() >= f + 28), 1);
        for (int k = 0; k < 28 && f >= 0 && f + k < obs_id.size(); k++)
            check_eq("t3_seq", obs_id[f+k], pat[k % 7]);

        // Fixed priority, channels 0 and 3 loaded together.
        do_reset();
        mode_in = 2'd2;
        repeat (6) begin drive(4'b1001); step(); end
        drive('0);
        repeat (16) step();
        check_eq("t4_count", obs_id.size(), 12);
        for (int k = 0; k < 12 && k < obs_id.size(); k++) check_eq("t4_id", obs_id[k], (k < 6) ? 0 : 3);

        // Downstream stall while channel 1 fills past full.
        do_reset();
        mode_in           = 2'd0;
        request_out_ready = 1'b0;
        repeat (20) begin drive(4'b0010); step(); end
        check_eq("t5_frozen", request_out_data, pushed[0]);
        check_eq("t5_ready1", request_ready_out[1], 0);
        check_eq("t5_ovf1", overflow_out[1], 1);
        drive('0);
        request_out_ready = 1'b1;
        repeat (22) step();
        check_eq("t5_count", obs_dat.size(), 17);
        for (int k = 0; k < 17 && k < obs_dat.size(); k++) check_eq("t5_order", obs_dat[k], pushed[k]);

        // Single channel streaming at full rate.
        do_reset();
        repeat (30) begin drive(4'b0100); step(); end
        drive('0);
        repeat (5) step();
        check_eq("t6_count", obs_dat.size(), 30);
        for (int k = 0; k < 30 && k < obs_dat.size(); k++) check_eq("t6_order", obs_dat[k], pushed[k]);
        if (obs_cyc.size() > 0) check_eq("t6_gapless", obs_cyc[obs_cyc.size()-1] - obs_cyc[0], 29);

        // Random traffic with mode/weight changes and a reset in the middle.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c % 40 == 0) begin
                mode_in   = 2'($urandom_range(0, 3));
                weight_in = N*WW'($urandom);
            end
            request_out_ready = ($urandom_range(0, 3) != 0);
            drive(N'($urandom_range(0, 15)) & ((c % 80 < 40) ? 4'hF : 4'h3));
            step();
            if (c == 200) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
